// File: rtl/avg_pool_divider.sv
// Average-pooling divide stage: sum * Q13 reciprocal of the window count,
// rounded half up and clipped to the signed output range, on a valid/ready stream.
module avg_pool_divider #(
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH  = 22
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [SUM_WIDTH-1:0]  in_sum,
    input  logic        [5:0]            in_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_sat
);

    localparam int PW = SUM_WIDTH + 15;
    localparam longint MAXI = (longint'(1) << (DATA_WIDTH - 1)) - 1;
    localparam logic signed [PW-1:0] MAXV = PW'(MAXI);
    localparam logic signed [PW-1:0] MINV = PW'(-MAXI - 1);
    localparam logic signed [PW-1:0] HALF = PW'(4096);

    logic [13:0] rom [64];

    for (genvar g = 0; g < 64; g++) begin : g_rom
        assign rom[g] = 14'(8192 / (g + 1));
    end

    logic advance;

    logic                        v0;
    logic                        v1;
    logic                        v2;
    logic signed [SUM_WIDTH-1:0] sum0;
    logic        [5:0]           idx0;
    logic signed [SUM_WIDTH-1:0] sum1;
    logic        [13:0]          frac1;
    logic signed [PW-1:0]        prod2;

    logic signed [PW-1:0]         rnd;
    logic signed [DATA_WIDTH-1:0] data_n;
    logic                         sat_n;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Slot valids shift together; a stalled output freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v0        <= in_valid;
            v1        <= v0;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    // Datapath: capture, registered reciprocal read, then the product.
    always_ff @(posedge clk) begin
        if (advance) begin
            sum0  <= in_sum;
            idx0  <= in_idx;
            sum1  <= sum0;
            frac1 <= rom[idx0];
            prod2 <= $signed(sum1) * $signed({1'b0, frac1});
        end
    end

    // Round half up in Q13 and clip to the output range.
    always_comb begin
        rnd    = (prod2 + HALF) >>> 13;
        data_n = rnd[DATA_WIDTH-1:0];
        sat_n  = 1'b0;
        if (rnd > MAXV) begin
            data_n = MAXV[DATA_WIDTH-1:0];
            sat_n  = 1'b1;
        end else if (rnd < MINV) begin
            data_n = MINV[DATA_WIDTH-1:0];
            sat_n  = 1'b1;
        end
    end

    // Output register; only loads real samples, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (advance && v2) begin
            out_data <= data_n;
            out_sat  <= sat_n;
        end
    end

endmodule

// File: tb/tb_avg_pool_divider.sv
// Bench for avg_pool_divider: directed cases, backpressure, reset,
// reciprocal sweep and random streaming against an arithmetic model.
module tb_avg_pool_divider;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [21:0] in_sum;
    logic        [5:0]  in_idx;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_sat;

    typedef struct {
        longint d;
        longint s;
    } res_t;

    res_t   q[$];
    int     n_run;
    int     n_fail;
    bit     hold_pend;
    longint hold_d;
    longint hold_s;
    bit     done;

    avg_pool_divider #(
        .DATA_WIDTH(16),
        .SUM_WIDTH (22)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_idx   (in_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic signed [21:0] s,
                                   input logic [5:0] i);
        res_t   r;
        longint p;
        longint a;
        p = longint'(s) * longint'(8192 / (int'(i) + 1));
        a = (p + 4096) >>> 13;
        r.s = 0;
        if (a > 32767) begin
            a   = 32767;
            r.s = 1;
        end else if (a < -32768) begin
            a   = -32768;
            r.s = 1;
        end
        r.d = a;
        return r;
    endfunction

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_d);
                chk("hold_sat", out_sat, hold_s);
            end
            hold_pend = out_valid && !out_ready;
            hold_d    = out_data;
            hold_s    = out_sat;
            if (in_valid && in_ready) q.push_back(model(in_sum, in_idx));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_out", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", out_data, e.d);
                    chk("sb_sat", out_sat, e.s);
                end
            end
        end else begin
            hold_pend = 0;
        end
    end

    task automatic send(input logic signed [21:0] s, input logic [5:0] i);
        bit ok;
        in_sum   = s;
        in_idx   = i;
        in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_to", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic one(input string tag, input logic signed [21:0] s,
                       input logic [5:0] i, input longint ed, input longint es);
        send(s, i);
        chk({tag, "_v0"}, out_valid, 0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            chk({tag, "_lat"}, out_valid, (c == 3));
        end
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_sat"}, out_sat, es);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, out_valid, 0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
        #1;
        chk(tag, q.size(), 0);
    endtask

    initial begin
        int n;
        logic signed [21:0] s;
        n_run     = 0;
        n_fail    = 0;
        hold_pend = 0;
        done      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_idx    = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        one("t1", 30, 2, 10, 0);
        one("t2a", -9, 2, -3, 0);
        one("t2b", 7, 0, 7, 0);
        one("t2c", 640, 63, 10, 0);
        one("t3a", 40000, 0, 32767, 1);
        one("t3b", -40000, 0, -32768, 1);
        one("t3c", 32767, 0, 32767, 0);

        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 8; k++)
                    send(22'(($urandom_range(0, 4000)) - 2000),
                         6'($urandom_range(0, 63)));
            end
        join
        drain("t4_drain");

        send(1000, 1);
        send(-2000, 3);
        send(3000, 5);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_sat", out_sat, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        one("t5_new", 90, 8, 10, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("t5_stale", out_valid, 0);

        for (int i = 0; i < 64; i++) begin
            n = $urandom_range(1, 7);
            s = 22'(8192 * n);
            if ($urandom_range(0, 1) == 1) s = -s;
            send(s, 6'(i));
        end
        drain("t6_drain");

        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    n = $urandom_range(0, 2);
                    if (n > 0) begin
                        repeat (n) @(posedge clk);
                        #1;
                    end
                    send(22'($urandom), 6'($urandom_range(0, 63)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("rnd_drain");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
